// File: rtl/load_store_unit.sv
// load_store_unit: LOAD/STORE/LOADI/STOREI sequencer with MAR/MBR registers,
// a req/ack memory port with timeout abort, and a registered accumulator port.
module load_store_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] x,
  input  logic [DATA_W-1:0] ac_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ac_we,
  output logic [DATA_W-1:0] ac_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [2:0] {IDLE, IND, GAP, ACC, WB} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [1:0] op_r;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic [CW-1:0] cnt;
  logic expired;
  // The edge that would see the TIMEOUT-th unacknowledged request cycle aborts.
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign busy = state != IDLE;
  assign mem_req = state == IND || state == ACC;
  assign mem_we = state == ACC && op_r[0];
  assign mem_addr = mar;
  assign mem_wdata = mbr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_r <= '0;
      mar <= '0;
      mbr <= '0;
      cnt <= '0;
      ac_out <= '0;
      done <= 1'b0;
      err <= 1'b0;
      ac_we <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      ac_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mar <= x;
          mbr <= ac_in;
          op_r <= op;
          cnt <= '0;
          state <= op[1] ? IND : ACC;
        end
        GAP: begin
          cnt <= '0;
          state <= ACC;
        end
        IND, ACC: if (mem_ack) begin
          // Ack wins over a coincident timeout.
          if (state == IND) mar <= mem_rdata[ADDR_W-1:0];
          if (state == ACC && !op_r[0]) mbr <= mem_rdata;
          done <= state == ACC && op_r[0];
          state <= state == IND ? GAP : (op_r[0] ? IDLE : WB);
        end else if (expired) begin
          done <= 1'b1;
          err <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        WB: begin
          ac_out <= mbr;
          ac_we <= 1'b1;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized LSU operations checked against a
// transaction-level model of memory, accumulator and completion latency.
module tb_load_store_unit;
  localparam int DW = 16, AW = 12, TO = 4;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
  logic clk = 0, rst = 1, start = 0, mem_ack = 0, force_ack = 0;
  logic [1:0] op = 0;
  logic [AW-1:0] x = 0;
  logic [DW-1:0] ac_in = 0, mem_rdata = 0;
  logic busy, done, err, ac_we, mem_req, mem_we;
  logic [DW-1:0] ac_out, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] ref_ac = 0;
  int lat_q[$];
  req_t exp_q[$];
  req_t cur, e;
  int total = 0, fails = 0, rcnt = 0, cur_lat = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .ac_in(ac_in),
    .busy(busy), .done(done), .err(err), .ac_we(ac_we), .ac_out(ac_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks the lat-th cycle of each request (lat 0 = never).
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      rcnt = 0;
      mem_ack = force_ack;
    end else begin
      if (rcnt == 0) begin
        cur_lat = 1;
        if (lat_q.size() != 0) cur_lat = lat_q.pop_front();
        cur = '{mem_we, mem_addr, mem_wdata};
        chk("req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("req_we", mem_we, e.we);
          chk("req_addr", mem_addr, e.addr);
          if (e.we) chk("req_wdata", mem_wdata, e.wdata);
        end
      end else chk("req_stable", {mem_we, mem_addr, mem_wdata}, {cur.we, cur.addr, cur.wdata});
      rcnt++;
      mem_ack = cur_lat != 0 && rcnt == cur_lat;
      mem_rdata = mem_ack ? mem[mem_addr] : DW'($urandom);
      if (mem_ack && mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // Caller is positioned #1 after a rising edge; returning leaves it there,
  // so a following call issues its start in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int l1, input int l2, input bit noise);
    int edges = 0, n = 0;
    bit e_err = 0, e_we = 0, seen_we = 0;
    logic [AW-1:0] p = a;
    if (o[1]) begin
      lat_q.push_back(l1);
      exp_q.push_back('{1'b0, p, DW'(0)});
      if (l1 == 0) begin edges = TO; e_err = 1; end
      else begin edges = l1 + 1; p = ref_mem[p][AW-1:0]; end
    end
    if (!e_err) begin
      lat_q.push_back(l2);
      exp_q.push_back('{o[0], p, d});
      if (l2 == 0) begin edges += TO; e_err = 1; end
      else if (o[0]) begin edges += l2; ref_mem[p] = d; end
      else begin edges += l2 + 1; ref_ac = ref_mem[p]; e_we = 1; end
    end
    start = 1; op = o; x = a; ac_in = d;
    @(posedge clk); #1;
    start = 0;
    while (!done && n < 60) begin
      if (ac_we) seen_we = 1;
      if (noise) begin
        start = 1'($urandom_range(0, 1)); op = 2'($urandom); x = AW'($urandom); ac_in = DW'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    chk("done_latency", n, edges);
    chk("err", err, e_err);
    chk("ac_we", ac_we, e_we);
    chk("ac_out", ac_out, ref_ac);
    chk("busy_at_done", busy, 0);
    chk("early_ac_we", seen_we, 0);
    chk("reqs_issued", exp_q.size(), 0);
    lat_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = DW'($urandom) & 16'hF01F;
      ref_mem[i] = mem[i];
    end
    mem[5] = 16'hBEEF; ref_mem[5] = 16'hBEEF;
    mem[16] = 16'hF020; ref_mem[16] = 16'hF020;
    mem[32] = 16'h00C3; ref_mem[32] = 16'h00C3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ac_we", ac_we, 0);
    chk("rst_ac_out", ac_out, 0);
    chk("rst_mem_req", mem_req, 0);
    rst = 0;
    @(posedge clk); #1;
    run_op(2'b00, 12'h005, 16'h0, 0, 1, 0);
    run_op(2'b01, 12'h0A0, 16'h1234, 0, 3, 0);
    chk("store_mem", mem[12'h0A0], 16'h1234);
    run_op(2'b10, 12'h010, 16'h0, 1, 1, 0);
    chk("loadi_ac", ac_out, 16'h00C3);
    run_op(2'b00, 12'h007, 16'h0, 0, 0, 0);
    run_op(2'b00, 12'h005, 16'h0, 0, TO, 0);
    run_op(2'b10, 12'h010, 16'h0, TO, 0, 0);
    run_op(2'b11, 12'h011, 16'h5A5A, 0, 2, 1);
    // Reset mid-ACC of a STOREI whose data write is never acknowledged.
    lat_q.push_back(1);
    lat_q.push_back(0);
    exp_q.push_back('{1'b0, 12'h0A0, DW'(0)});
    exp_q.push_back('{1'b1, ref_mem[12'h0A0][AW-1:0], 16'hCAFE});
    start = 1; op = 2'b11; x = 12'h0A0; ac_in = 16'hCAFE;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("gap_no_req", mem_req, 0);
    @(posedge clk); #1;
    chk("acc_req", {mem_req, mem_we}, 2'b11);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ac_out", ac_out, 0);
    chk("arst_flags", {done, err, ac_we}, 0);
    ref_ac = 0;
    lat_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    force_ack = 1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("late_ack_ignored", {busy, done, ac_we, mem_req}, 0);
    end
    force_ack = 0;
    @(posedge clk); #1;
    run_op(2'b00, 12'h005, 16'h0, 0, 2, 0);
    for (int t = 0; t < 150; t++) begin
      int l1 = $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, TO);
      int l2 = $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, TO);
      run_op(2'($urandom), AW'($urandom_range(0, 31)), DW'($urandom), l1, l2, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bad = 0;
    for (int i = 0; i < 2**AW; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
